// File: rtl/alt_vipcti121_avst_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alt_vipcti121_avst_pkg : shared field indices and FSM encoding            |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package alt_vipcti121_avst_pkg;

    localparam int DEFAULT_DATA_WIDTH = 20;
    localparam int SOP_BIT            = DEFAULT_DATA_WIDTH + 1;
    localparam int EOP_BIT            = DEFAULT_DATA_WIDTH;

    // Field positions for an arbitrary pixel width; the FIFO word is {sop, eop, pixel}
    function automatic int sop_bit(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int eop_bit(input int data_width);
        return data_width;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_PKT   = 2'd1,
        ST_WAIT_SOP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alt_vipcti121_skid_buf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alt_vipcti121_skid_buf : 2-entry FIFO-ordered buffer, head registered     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module alt_vipcti121_skid_buf #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o,
    output logic             head_valid_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) head_d = din_i;
                else                 tail_d = din_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // With one entry the incoming word becomes the new head directly
                if (count_q == 2'd1) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            assert (!(push_i && !pop_i && count_q == 2'd2));
            assert (!(pop_i && count_q == 2'd0));
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_o       = head_q;
    assign head_valid_o = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: rtl/alt_vipcti121_avst_output.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alt_vipcti121_avst_output : CDC FIFO reader -> Avalon-ST video source     |
// | Optional SOP alignment: define ALT_VIPCTI121_SOP_ALIGN_EN. Rev 1.0        |
// +---------------------------------------------------------------------------+
module alt_vipcti121_avst_output
    import alt_vipcti121_avst_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rdreq_o,
    input  logic                  fifo_rdempty_i,
    input  logic [DATA_WIDTH+1:0] fifo_q_i,
    input  logic                  dout_ready_i,
    output logic                  dout_valid_o,
    output logic [DATA_WIDTH-1:0] dout_data_o,
    output logic                  dout_startofpacket_o,
    output logic                  dout_endofpacket_o,
    output logic [CNT_WIDTH-1:0]  pkt_count_o,
    output logic                  proto_err_o
);

    localparam int WORD_W   = DATA_WIDTH + 2;
    localparam int SOP_IDX  = sop_bit(DATA_WIDTH);
    localparam int EOP_IDX  = eop_bit(DATA_WIDTH);
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
    localparam state_t RESET_STATE = ST_WAIT_SOP;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    logic              inflight_q;
    logic [1:0]        buf_count;
    logic [WORD_W-1:0] head;
    logic              head_valid;
    logic              head_sop, head_eop;
    logic              drop, pop, free_slot;
    logic [2:0]        used;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 err_evt;

    assign head_sop = head[SOP_IDX];
    assign head_eop = head[EOP_IDX];

`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
    assign drop = head_valid & (state_q == ST_WAIT_SOP) & ~head_sop;
`else
    assign drop = 1'b0;
`endif

    assign dout_valid_o = head_valid & ~drop;
    assign pop          = dout_valid_o & dout_ready_i;
    assign free_slot    = pop | drop;

    // Credits: a read is only issued if the word is guaranteed a slot when it lands
    assign used         = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, free_slot};
    assign fifo_rdreq_o = ~rst & ~fifo_rdempty_i & (used < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= fifo_rdreq_o;
    end

    alt_vipcti121_skid_buf #(
        .WIDTH (WORD_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (inflight_q),
        .din_i        (fifo_q_i),
        .pop_i        (free_slot),
        .count_o      (buf_count),
        .head_o       (head),
        .head_valid_o (head_valid)
    );

    assign dout_data_o          = head[DATA_WIDTH-1:0];
    assign dout_startofpacket_o = head_sop;
    assign dout_endofpacket_o   = head_eop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        err_evt = 1'b0;
        if (pop) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (head_sop) begin
                        if (head_eop) cnt_d = cnt_q + CNT_WIDTH'(1);
                        else          state_d = ST_IN_PKT;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (head_sop) err_evt = 1'b1;
                    if (head_eop) begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = ST_IDLE;
                    end
                end
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
                ST_WAIT_SOP: begin
                    // Only SOP words are ever presented in this state
                    if (head_eop) begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IN_PKT;
                    end
                end
`endif
                default: state_d = RESET_STATE;
            endcase
        end
        if (err_evt) begin
            err_d = 1'b1;
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
            state_d = ST_WAIT_SOP;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pkt_count_o = cnt_q;
    assign proto_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alt_vipcti121_avst_output.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_alt_vipcti121_avst_output : FIFO model, packet-level reference, checks |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_alt_vipcti121_avst_output;
    import alt_vipcti121_avst_pkg::*;

    localparam int DW = 20;
    localparam int CW = 16;
    typedef logic [DW+1:0] word_t;

    typedef struct {
        int    n;
        word_t w [6];
        int    rmode;
        bit    etog;
        int    exp_pkt;
        bit    exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_rdreq;
    logic          fifo_rdempty = 1'b1;
    word_t         fifo_q = '0;
    logic          ready = 1'b1;
    logic          valid;
    logic [DW-1:0] data;
    logic          sop, eop;
    logic [CW-1:0] pkt;
    logic          err;

    int    checks = 0;
    int    errors = 0;
    word_t fifo_mem [$];
    word_t sb [$];
    int    beat_cyc [$];
    int    cyc = 0;
    bit    tog = 1'b0;
    bit    etog_en = 1'b0;
    logic  rdreq_s = 1'b0;
    int    rmode = 0;
    int    outstanding = 0;
    bit    stalled = 1'b0;
    word_t held = '0;
    int    exp_cnt = 0;
    bit    exp_err = 1'b0;
    bit    ref_in = 1'b0;
    bit    ref_wait = 1'b0;
    vec_t  vt [5];

    alt_vipcti121_avst_output #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fifo_rdreq_o         (fifo_rdreq),
        .fifo_rdempty_i       (fifo_rdempty),
        .fifo_q_i             (fifo_q),
        .dout_ready_i         (ready),
        .dout_valid_o         (valid),
        .dout_data_o          (data),
        .dout_startofpacket_o (sop),
        .dout_endofpacket_o   (eop),
        .pkt_count_o          (pkt),
        .proto_err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic word_t mk(input bit s, input bit e, input int d);
        word_t w;
        w          = '0;
        w[SOP_BIT] = s;
        w[EOP_BIT] = e;
        w[DW-1:0]  = d[DW-1:0];
        return w;
    endfunction

    // Packet-level reference: decides which words appear and how the counters move
    task automatic ref_word(input word_t w);
        bit s, e, bad;
        s = w[SOP_BIT];
        e = w[EOP_BIT];
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
        if (ref_wait && !s) return;
        ref_wait = 1'b0;
`endif
        sb.push_back(w);
        bad = (s && ref_in) || (!s && !ref_in);
        if (e && (s || ref_in)) begin
            exp_cnt++;
            ref_in = 1'b0;
        end else if (s) begin
            ref_in = 1'b1;
        end
        if (bad) begin
            exp_err = 1'b1;
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
            ref_wait = 1'b1;
            ref_in   = 1'b0;
`endif
        end
    endtask

    // Non-showahead FIFO: a read sampled at an edge shows its word in the following cycle
    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        if (rst) fifo_mem.delete();
        else if (rdreq_s && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        tog          = ~tog;
        fifo_rdempty = (fifo_mem.size() == 0) || (etog_en && tog);
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            2:       ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    end

    initial forever begin
        @(negedge clk);
        rdreq_s = fifo_rdreq;
        if (rst) begin
            outstanding = 0;
            stalled     = 1'b0;
        end else begin
            if (stalled) chk("stall_stable", {valid, sop, eop, data}, {1'b1, held});
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {sop, eop, data}, '1);
                end else begin
                    chk("beat", {sop, eop, data}, sb.pop_front());
                    beat_cyc.push_back(cyc);
                end
            end
`ifndef ALT_VIPCTI121_SOP_ALIGN_EN
            if (fifo_rdreq) chk("rdreq_credit", (outstanding - int'(valid && ready)) < 2, 1);
            outstanding = outstanding + int'(fifo_rdreq) - int'(valid && ready);
`endif
            stalled = valid && !ready;
            held    = {sop, eop, data};
        end
    end

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        rmode   = 0;
        etog_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        beat_cyc.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        ref_in  = 1'b0;
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
        ref_wait = 1'b1;
`else
        ref_wait = 1'b0;
`endif
        #3;
        chk("rst_valid", valid, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        chk("rst_outs", {sop, eop, data}, 0);
        chk("rst_pkt_err", {pkt, err}, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || fifo_mem.size() > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < 3000, 1);
        rmode = 0;
        repeat (4) @(posedge clk);
        #3;
        chk("idle_after_drain", valid, 0);
    endtask

    initial begin
        int pcyc;
        vt[0] = '{4, '{mk(1,0,1), mk(0,0,2), mk(0,0,3), mk(0,1,4), '0, '0}, 0, 1'b0, 1, 1'b0};
        vt[1] = '{4, '{mk(1,0,1), mk(0,0,2), mk(0,0,3), mk(0,1,4), '0, '0}, 1, 1'b0, 1, 1'b0};
        vt[2] = '{6, '{mk(1,0,16), mk(0,0,17), mk(0,0,18), mk(0,0,19), mk(0,0,20), mk(0,1,21)},
                  0, 1'b1, 1, 1'b0};
`ifdef ALT_VIPCTI121_SOP_ALIGN_EN
        vt[3] = '{4, '{mk(1,0,1), mk(0,0,2), mk(1,0,3), mk(0,1,4), '0, '0}, 0, 1'b0, 0, 1'b1};
        vt[4] = '{4, '{mk(0,0,'h0AA), mk(0,1,'h0BB), mk(1,0,1), mk(0,1,2), '0, '0}, 0, 1'b0, 1, 1'b0};
`else
        vt[3] = '{4, '{mk(1,0,1), mk(0,0,2), mk(1,0,3), mk(0,1,4), '0, '0}, 0, 1'b0, 1, 1'b1};
        vt[4] = '{4, '{mk(0,0,'h0AA), mk(0,1,'h0BB), mk(1,0,1), mk(0,1,2), '0, '0}, 0, 1'b0, 1, 1'b1};
`endif
        repeat (3) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            reset_dut();
            @(posedge clk);
            #1;
            rmode   = vt[i].rmode;
            etog_en = vt[i].etog;
            pcyc    = cyc;
            for (int k = 0; k < vt[i].n; k++) begin
                ref_word(vt[i].w[k]);
                fifo_mem.push_back(vt[i].w[k]);
            end
            wait_drain();
            chk($sformatf("vec%0d_pkt", i), pkt, vt[i].exp_pkt);
            chk($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            chk($sformatf("vec%0d_ref_pkt", i), pkt, exp_cnt[CW-1:0]);
            if (i == 0) begin
                chk("latency_nbeats", beat_cyc.size(), 4);
                for (int k = 0; k < beat_cyc.size(); k++)
                    chk($sformatf("latency_beat%0d", k), beat_cyc[k], pcyc + 2 + k);
            end
            etog_en = 1'b0;
        end

        // Reset with reads outstanding and words buffered discards everything
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            ref_word(vt[0].w[k]);
            fifo_mem.push_back(vt[0].w[k]);
        end
        wait_drain();
        chk("t5_pkt_before", pkt, 1);
        rmode = 3;
        @(posedge clk);
        #1;
        ready = 1'b0;
        for (int k = 0; k < 4; k++) fifo_mem.push_back(vt[0].w[k]);
        repeat (2) @(posedge clk);
        #3;
        chk("t5_valid_before", valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        ref_in  = 1'b0;
        #3;
        chk("t5_valid_after", valid, 0);
        chk("t5_rdreq_after", fifo_rdreq, 0);
        chk("t5_pkt_after", pkt, 0);
        rmode = 0;
        repeat (4) @(posedge clk);
        #3;
        chk("t5_no_leak", valid, 0);

        // Randomised bursts with random backpressure against the reference model
        reset_dut();
        rmode = 2;
        for (int b = 0; b < 40; b++) begin
            int len;
            word_t w;
            len = $urandom_range(1, 10);
            @(posedge clk);
            #1;
            for (int k = 0; k < len; k++) begin
                w = mk($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, int'($urandom));
                ref_word(w);
                fifo_mem.push_back(w);
            end
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        wait_drain();
        chk("rand_pkt", pkt, exp_cnt[CW-1:0]);
        chk("rand_err", err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
